// File: rtl/matrix_capture_if.sv
// Scanned-matrix stream and captured-frame outputs for matrix_capture.
// The master drives the scan stream; the slave (the capture block) returns the frame.
interface matrix_capture_if #(
    parameter int gs = 8
);
    localparam int RW = $clog2(gs);

    logic              en_i;
    logic [gs-1:0]     col_val_i;
    logic [gs-1:0]     row_val_i;
    logic              d_disp_i;
    logic [gs*gs-1:0]  matrix_o;
    logic              frame_valid_o;
    logic              err_o;
    logic [RW-1:0]     row_idx_o;
    logic [7:0]        frame_cnt_o;

    modport master (
        output en_i, col_val_i, row_val_i, d_disp_i,
        input  matrix_o, frame_valid_o, err_o, row_idx_o, frame_cnt_o
    );

    modport slave (
        input  en_i, col_val_i, row_val_i, d_disp_i,
        output matrix_o, frame_valid_o, err_o, row_idx_o, frame_cnt_o
    );
endinterface

// File: rtl/matrix_capture.sv
// Rebuilds a gs x gs frame from a row-scanned stream into a shadow buffer and
// publishes it to matrix_o only once all rows have arrived in strict order.
module matrix_capture #(
    parameter int gs = 8
) (
    input logic             clk_i,
    input logic             rst_n_i,
    matrix_capture_if.slave bus
);
    localparam int RW = $clog2(gs);
    localparam logic [RW-1:0] LAST_IDX  = RW'(gs - 1);
    localparam logic [gs-1:0] FIRST_ROW = {{(gs-1){1'b0}}, 1'b1};
    localparam logic [gs-1:0] LAST_ROW  = {1'b1, {(gs-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CAPTURE, ERROR} state_t;

    state_t           state_q, state_d;
    logic [gs*gs-1:0] shadow_q, shadow_d;
    logic [gs*gs-1:0] matrix_q, matrix_d;
    logic             frame_valid_q, frame_valid_d;
    logic [RW-1:0]    row_idx_q, row_idx_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [gs-1:0]    expected_strobe;

    assign expected_strobe = FIRST_ROW << row_idx_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            matrix_q      <= '0;
            frame_valid_q <= 1'b0;
            row_idx_q     <= '0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            matrix_q      <= matrix_d;
            frame_valid_q <= frame_valid_d;
            row_idx_q     <= row_idx_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Dropping en_i wins over everything; stale shadow rows are harmless because
    // a commit is only reachable after every row has been rewritten in order.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        matrix_d      = matrix_q;
        frame_valid_d = 1'b0;
        row_idx_d     = row_idx_q;
        frame_cnt_d   = frame_cnt_q;

        if (!bus.en_i) begin
            state_d   = IDLE;
            row_idx_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.row_val_i == FIRST_ROW) begin
                        shadow_d[gs-1:0] = bus.col_val_i;
                        row_idx_d        = RW'(1);
                        state_d          = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.row_val_i != '0) begin
                        if (bus.row_val_i == expected_strobe && row_idx_q != LAST_IDX
                            && !bus.d_disp_i) begin
                            shadow_d[gs*row_idx_q +: gs] = bus.col_val_i;
                            row_idx_d = row_idx_q + RW'(1);
                        end else if (bus.row_val_i == LAST_ROW && row_idx_q == LAST_IDX
                                     && bus.d_disp_i) begin
                            matrix_d                    = shadow_q;
                            matrix_d[gs*(gs-1) +: gs]   = bus.col_val_i;
                            frame_valid_d               = 1'b1;
                            frame_cnt_d                 = frame_cnt_q + 8'd1;
                            row_idx_d                   = '0;
                            state_d                     = IDLE;
                        end else begin
                            state_d = ERROR;
                        end
                    end
                end
                ERROR: state_d = ERROR;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.matrix_o      = matrix_q;
    assign bus.frame_valid_o = frame_valid_q;
    assign bus.err_o         = (state_q == ERROR);
    assign bus.row_idx_o     = row_idx_q;
    assign bus.frame_cnt_o   = frame_cnt_q;
endmodule

// File: tb/tb_matrix_capture.sv
// Scoreboarded bench for matrix_capture: committed frames are queued as they are
// sent and a negedge monitor pops them whenever frame_valid_o pulses.
module tb_matrix_capture;
    typedef struct {
        logic [63:0] m;
        logic [7:0]  c;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   total_checks;
    int   passed_checks;
    int   pulses;
    logic [7:0] exp_cnt;

    matrix_capture_if #(.gs(8)) bus ();

    matrix_capture #(.gs(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        total_checks++;
        if (act === req) passed_checks++;
        else $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // One beat: drive the stream, let one rising edge sample it, settle 1 time unit past it.
    task automatic apply_stimulus(input logic en, input logic [7:0] row, input logic [7:0] col,
                                  input logic disp);
        bus.en_i      = en;
        bus.row_val_i = row;
        bus.col_val_i = col;
        bus.d_disp_i  = disp;
        @(posedge clk);
        #1;
    endtask

    task automatic send_rows(input int n, input logic [63:0] frm);
        for (int r = 0; r < n; r++)
            apply_stimulus(1'b1, 8'(1 << r), frm[8*r +: 8], 1'b0);
    endtask

    task automatic send_frame(input logic [63:0] frm, input int stalls);
        exp_t e;
        for (int r = 0; r < 8; r++) begin
            if (r == 4 && stalls > 0) begin
                repeat (stalls) apply_stimulus(1'b1, 8'h00, 8'hFF, 1'b0);
                check_output("stall_row_idx", 64'(bus.row_idx_o), 64'd4);
            end
            if (r == 7) begin
                exp_cnt = exp_cnt + 8'd1;
                e.m = frm;
                e.c = exp_cnt;
                exp_q.push_back(e);
            end
            apply_stimulus(1'b1, 8'(1 << r), frm[8*r +: 8], r == 7);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.frame_valid_o) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check_output("unexpected_pulse", 64'(bus.frame_valid_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("frame_matrix", bus.matrix_o, e.m);
                check_output("frame_cnt", 64'(bus.frame_cnt_o), 64'(e.c));
            end
        end
    end

    localparam logic [63:0] FRAME_A = 64'hA7A6A5A4A3A2A1A0;
    localparam logic [63:0] FRAME_5 = {8{8'h5A}};
    localparam logic [63:0] FRAME_P = 64'h1716151413121110;

    initial begin
        logic [63:0] frm;
        int base_pulses;
        total_checks  = 0;
        passed_checks = 0;
        pulses        = 0;
        exp_cnt       = 8'd0;
        rst_n         = 1'b0;
        bus.en_i      = 1'b0;
        bus.row_val_i = 8'h00;
        bus.col_val_i = 8'h00;
        bus.d_disp_i  = 1'b0;
        #2;
        check_output("reset_matrix", bus.matrix_o, 64'd0);
        check_output("reset_cnt", 64'(bus.frame_cnt_o), 64'd0);
        check_output("reset_err", 64'(bus.err_o), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean frame then the same frame with a three-cycle stall.
        send_frame(FRAME_A, 0);
        apply_stimulus(1'b1, 8'h00, 8'h00, 1'b0);
        check_output("full_err", 64'(bus.err_o), 64'd0);
        check_output("full_row_idx", 64'(bus.row_idx_o), 64'd0);
        send_frame(FRAME_A, 3);
        apply_stimulus(1'b1, 8'h00, 8'h00, 1'b0);

        // Skipped row: error, old frame kept, error ignores a would-be commit.
        send_rows(2, FRAME_P);
        apply_stimulus(1'b1, 8'h08, 8'h33, 1'b0);
        check_output("skip_err", 64'(bus.err_o), 64'd1);
        check_output("skip_matrix", bus.matrix_o, FRAME_A);
        check_output("skip_cnt", 64'(bus.frame_cnt_o), 64'd2);
        apply_stimulus(1'b1, 8'h80, 8'h44, 1'b1);
        check_output("error_sticky", 64'(bus.err_o), 64'd1);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
        check_output("clear_err", 64'(bus.err_o), 64'd0);
        send_frame(FRAME_5, 0);
        apply_stimulus(1'b1, 8'h00, 8'h00, 1'b0);

        // Abort after row 4, then early last-row flag on row 5.
        send_rows(5, FRAME_P);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
        check_output("abort_row_idx", 64'(bus.row_idx_o), 64'd0);
        check_output("abort_matrix", bus.matrix_o, FRAME_5);
        check_output("abort_cnt", 64'(bus.frame_cnt_o), 64'd3);
        send_rows(5, FRAME_P);
        apply_stimulus(1'b1, 8'h20, 8'h15, 1'b1);
        check_output("early_flag_err", 64'(bus.err_o), 64'd1);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);

        // Non-one-hot strobe and last row without the flag.
        send_rows(1, FRAME_P);
        apply_stimulus(1'b1, 8'h06, 8'h11, 1'b0);
        check_output("onehot_err", 64'(bus.err_o), 64'd1);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);
        send_rows(7, FRAME_P);
        apply_stimulus(1'b1, 8'h80, 8'h17, 1'b0);
        check_output("noflag_err", 64'(bus.err_o), 64'd1);
        check_output("noflag_matrix", bus.matrix_o, FRAME_5);
        apply_stimulus(1'b0, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset between edges in the middle of a frame.
        send_rows(3, FRAME_P);
        #3 rst_n = 1'b0;
        #1;
        check_output("async_matrix", bus.matrix_o, 64'd0);
        check_output("async_cnt", 64'(bus.frame_cnt_o), 64'd0);
        check_output("async_row_idx", 64'(bus.row_idx_o), 64'd0);
        exp_cnt = 8'd0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply_stimulus(1'b1, 8'h04, 8'h99, 1'b0);
        check_output("late_join_row_idx", 64'(bus.row_idx_o), 64'd0);
        check_output("late_join_err", 64'(bus.err_o), 64'd0);
        send_frame(FRAME_P, 0);

        // 256 back-to-back frames wrap the counter through 255 -> 0.
        base_pulses = pulses;
        for (int k = 0; k < 256; k++) begin
            frm = {8{8'(k)}} ^ 64'h8040201008040201;
            send_frame(frm, 0);
        end
        repeat (3) apply_stimulus(1'b1, 8'h00, 8'h00, 1'b0);
        check_output("wrap_pulses", 64'(pulses - base_pulses), 64'd257);
        check_output("wrap_final_cnt", 64'(bus.frame_cnt_o), 64'd1);
        check_output("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
